leaderboard_reader: RTL

LEADERBOARD_READER -- requirements
Module: leaderboard_reader

---
 rtl/leaderboard_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/leaderboard_reader.sv
// Scans leaderboard ranks 0..2: reads each entry, converts its score to BCD one step per cycle, then holds it for DWELL_CYCLES.
// Reads use a req/ack handshake with a bounded wait; an unanswered read shows as 0/0/0 with id 0.
module leaderboard_reader #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       refresh,
  output logic       rd_req,
  output logic [1:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_score,
  input  logic [3:0] rd_id,
  output logic [1:0] disp_rank,
  output logic [3:0] disp_hund,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_id,
  output logic       disp_valid,
  output logic       busy
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 5) ? $clog2(ACK_TIMEOUT + 1) : 5;

  typedef enum logic [1:0] {IDLE, REQ, CONV, SHOW} state_t;

  state_t        state;
  logic [1:0]    index;
  logic [1:0]    next_index;
  logic [DW-1:0] dwell_cnt;
  logic [TW-1:0] ack_cnt;
  logic [7:0]    rem;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic [3:0]    cap_id;
  logic          ack_timeout;

  always_comb begin
    next_index  = (index == 2'd2) ? 2'd0 : index + 2'd1;
    ack_timeout = (ack_cnt == TW'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      index      <= 2'd0;
      dwell_cnt  <= '0;
      ack_cnt    <= '0;
      rem        <= 8'd0;
      hund       <= 4'd0;
      tens       <= 4'd0;
      cap_id     <= 4'd0;
      rd_req     <= 1'b0;
      rd_addr    <= 2'd0;
      disp_rank  <= 2'd0;
      disp_hund  <= 4'd0;
      disp_tens  <= 4'd0;
      disp_ones  <= 4'd0;
      disp_id    <= 4'd0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      rd_req     <= 1'b0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (refresh || state == IDLE) begin
      // A refresh abandons whatever is in flight, including a same-cycle ack.
      state      <= REQ;
      index      <= 2'd0;
      rd_addr    <= 2'd0;
      rd_req     <= 1'b1;
      ack_cnt    <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        REQ: begin
          if (rd_ack || ack_timeout) begin
            rem    <= rd_ack ? rd_score : 8'd0;
            cap_id <= rd_ack ? rd_id : 4'd0;
            hund   <= 4'd0;
            tens   <= 4'd0;
            rd_req <= 1'b0;
            state  <= CONV;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        CONV: begin
          if (rem >= 8'd100) begin
            rem  <= rem - 8'd100;
            hund <= hund + 4'd1;
          end else if (rem >= 8'd10) begin
            rem  <= rem - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            disp_rank  <= index;
            disp_hund  <= hund;
            disp_tens  <= tens;
            disp_ones  <= rem[3:0];
            disp_id    <= cap_id;
            disp_valid <= 1'b1;
            dwell_cnt  <= '0;
            busy       <= 1'b0;
            state      <= SHOW;
          end
        end
        SHOW: begin
          if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
            index   <= next_index;
            rd_addr <= next_index;
            rd_req  <= 1'b1;
            ack_cnt <= '0;
            busy    <= 1'b1;
            state   <= REQ;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
